arb_mux_n_to_1: RTL and testbench
=================================

ARB_MUX_N_TO_1 -- requirements
Module: arb_mux_n_to_1

Interface
REQ-001 SHALL have parameter WORD_LENGTH, default 32, data width in bits (>=1).
REQ-002 SHALL have parameter NUM_INPUTS, default 5, channel count (>=2).
REQ-003 SHALL have parameter MODE, default ARB_PRIORITY, arbitration mode (ARB_PRIORITY or ARB_ROUND_ROBIN).
REQ-004 SHALL have one clock and an asynchronous active-low reset: clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 data_in  input  NUM_INPUTS x WORD_LENGTH  per-channel data word.
REQ-007 sel  input  NUM_INPUTS  per-channel request/select, any number may be high.
REQ-008 out_ready  input  1  downstream accepts out this cycle.
REQ-009 clear_conflict  input  1  synchronous clear of conflict flag.
REQ-010 sel_ack  output  NUM_INPUTS  combinational one-hot: channel accepted this cycle.
REQ-011 out  output  WORD_LENGTH  registered selected word.
REQ-012 out_valid  output  1  out holds an unconsumed word.
REQ-013 grant  output  NUM_INPUTS  registered one-hot of channel that produced out.
REQ-014 grant_idx  output  $clog2(NUM_INPUTS)  registered binary index of that channel.
REQ-015 conflict  output  1  sticky: two or more sel seen on an accepting cycle.

Function
REQ-016 load = !out_valid || out_ready; accept = load && |sel.
REQ-017 On accept the winner's data SHALL appear on out one cycle later with out_valid=1, grant/grant_idx naming the winner (latency 1).
REQ-018 sel_ack SHALL be the winner one-hot when accept, else all-zero; never more than one bit set.
REQ-019 ARB_PRIORITY: lowest-index asserted sel wins.
REQ-020 ARB_ROUND_ROBIN: search starts at rr_ptr+1 modulo NUM_INPUTS, wraps past NUM_INPUTS-1 to 0; first asserted sel wins.
REQ-021 rr_ptr SHALL update to winner index only on accept; unchanged otherwise.
REQ-022 load with no sel: out SHALL hold its previous value (no latch, no X), out_valid<=0, grant<=0, grant_idx held.
REQ-023 out_valid=1 && out_ready=0 (stall): out, out_valid, grant, grant_idx, rr_ptr held; sel_ack=0; sel ignored.
REQ-024 out_valid=1 && out_ready=1 with new sel: back-to-back transfer, new word next cycle, no bubble.
REQ-025 conflict SHALL set on accept when popcount(sel)>=2; cleared by clear_conflict; set wins when both in same cycle.
REQ-026 Requests during stall SHALL NOT set conflict.

Reset
REQ-027 rst_n low SHALL asynchronously force out=0, out_valid=0, grant=0, grant_idx=0, conflict=0, rr_ptr=NUM_INPUTS-1 (channel 0 first after reset).
REQ-028 Reset mid-stall SHALL discard the held word; sel_ack=0 while rst_n low; first accept allowed on first rising edge after release.

Structure
REQ-029 Package mux_pkg SHALL hold typedef enum arb_mode_e {ARB_PRIORITY, ARB_ROUND_ROBIN} and shared index-width helper.
REQ-030 Combinational winner selection SHALL be sub-module rr_priority_picker (inputs req, start index; outputs one-hot, index, found); priority mode drives start=0.
REQ-031 Elaboration SHALL fail for NUM_INPUTS<2 or WORD_LENGTH<1.

Verification (WORD_LENGTH=8, NUM_INPUTS=5)
REQ-032 Priority: sel=5'b10110, data_in[1]=8'hA1, out_ready=1 -> sel_ack=5'b00010; next cycle out=8'hA1, grant_idx=1, conflict=1.
REQ-033 Round-robin: sel=5'b11111 held 6 cycles, out_ready=1 -> grant_idx sequence 0,1,2,3,4,0.
REQ-034 Stall: out=8'h3C valid, out_ready=0 for 3 cycles with sel=5'b00100 -> out stays 8'h3C, sel_ack=0, rr_ptr unchanged; out_ready=1 -> channel 2 word next cycle.
REQ-035 Idle hold: accept 8'h55, then sel=0 -> out_valid=0, out stays 8'h55, grant=0.
REQ-036 Conflict: set by sel=5'b00011, clear_conflict asserted with sel=5'b01001 same cycle -> conflict remains 1; clear alone next cycle -> 0.
REQ-037 Reset: assert rst_n=0 mid-stall -> out=0, out_valid=0 immediately; after release, round-robin with sel=5'b11111 grants 0 first.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared types and helpers for the N-to-1 arbitrated output mux.
// Contains the arbitration mode enum and the width function for channel indices.
// These are used by the mux top and by its winner-picker sub-module.
package mux_pkg;

  typedef enum logic {
    ARB_PRIORITY,
    ARB_ROUND_ROBIN
  } arb_mode_e;

  // Width of a binary channel index; never less than one bit.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Picks the first asserted request at or after a start index, wrapping from N-1 to 0.
// Latency: combinational only.
// Backpressure: none. The caller decides whether the pick is consumed.
module rr_priority_picker
  import mux_pkg::*;
#(
  parameter int N = 5
) (
  input  logic [N-1:0]              req,
  input  logic [idx_width(N)-1:0]   start,
  output logic [N-1:0]              onehot,
  output logic [idx_width(N)-1:0]   idx,
  output logic                      found
);

  localparam int IW = idx_width(N);

  // One extra bit holds start+offset before the modulo-N fold.
  logic [IW:0]   pos_sum;
  logic [IW-1:0] pos;

  always_comb begin
    onehot  = '0;
    idx     = '0;
    found   = 1'b0;
    pos_sum = '0;
    pos     = '0;
    for (int off = 0; off < N; off++) begin
      pos_sum = {1'b0, start} + (IW+1)'(off);
      if (pos_sum >= (IW+1)'(N)) begin
        pos_sum = pos_sum - (IW+1)'(N);
      end
      pos = pos_sum[IW-1:0];
      if (!found && req[pos]) begin
        found       = 1'b1;
        onehot[pos] = 1'b1;
        idx         = pos;
      end
    end
  end

endmodule

// File: rtl/arb_mux_n_to_1.sv
// N-to-1 arbitrated mux that supports fixed-priority or round-robin arbitration, with a sticky conflict flag.
// Latency: 1 cycle from accept to registered out/out_valid/grant.
// Backpressure: out_valid && !out_ready holds everything and ignores sel (sel_ack=0).
module arb_mux_n_to_1
  import mux_pkg::*;
#(
  parameter int        WORD_LENGTH = 32,
  parameter int        NUM_INPUTS  = 5,
  parameter arb_mode_e MODE        = ARB_PRIORITY
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [NUM_INPUTS-1:0][WORD_LENGTH-1:0] data_in,
  input  logic [NUM_INPUTS-1:0]                  sel,
  input  logic                                   out_ready,
  input  logic                                   clear_conflict,
  output logic [NUM_INPUTS-1:0]                  sel_ack,
  output logic [WORD_LENGTH-1:0]                 out,
  output logic                                   out_valid,
  output logic [NUM_INPUTS-1:0]                  grant,
  output logic [idx_width(NUM_INPUTS)-1:0]       grant_idx,
  output logic                                   conflict
);

  localparam int            IW   = idx_width(NUM_INPUTS);
  localparam logic [IW-1:0] LAST = IW'(NUM_INPUTS - 1);

  generate
    if (NUM_INPUTS < 2) begin : g_bad_num_inputs
      $error("arb_mux_n_to_1: NUM_INPUTS must be >= 2");
    end
    if (WORD_LENGTH < 1) begin : g_bad_word_length
      $error("arb_mux_n_to_1: WORD_LENGTH must be >= 1");
    end
  endgenerate

  logic [IW-1:0]         rr_ptr;
  logic [IW-1:0]         start;
  logic [NUM_INPUTS-1:0] win_oh;
  logic [IW-1:0]         win_idx;
  logic                  win_found;
  logic                  load;
  logic                  accept;
  logic                  multi_req;

  // In priority mode, the search is pinned to channel 0. In round-robin mode, it begins just past the last winner.
  always_comb begin
    start = '0;
    if (MODE == ARB_ROUND_ROBIN) begin
      start = (rr_ptr == LAST) ? '0 : rr_ptr + 1'b1;
    end
  end

  rr_priority_picker #(
    .N (NUM_INPUTS)
  ) u_picker (
    .req    (sel),
    .start  (start),
    .onehot (win_oh),
    .idx    (win_idx),
    .found  (win_found)
  );

  // win_found is equivalent to |sel.
  assign load      = !out_valid || out_ready;
  assign accept    = load && win_found;
  assign multi_req = |(sel & (sel - 1'b1));
  assign sel_ack   = (accept && rst_n) ? win_oh : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out       <= '0;
      out_valid <= 1'b0;
      grant     <= '0;
      grant_idx <= '0;
      rr_ptr    <= LAST;
    end else if (accept) begin
      out       <= data_in[win_idx];
      out_valid <= 1'b1;
      grant     <= win_oh;
      grant_idx <= win_idx;
      rr_ptr    <= win_idx;
    end else if (load) begin
      // Idle slot. The previous out word and grant_idx stay visible.
      out_valid <= 1'b0;
      grant     <= '0;
    end
  end

  // If a set and a clear occur in the same cycle, the set wins. A stalled request cannot set the flag because accept is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conflict <= 1'b0;
    end else if (accept && multi_req) begin
      conflict <= 1'b1;
    end else if (clear_conflict) begin
      conflict <= 1'b0;
    end
  end

endmodule

// File: tb/tb_arb_mux_n_to_1.sv
// Bench for arb_mux_n_to_1. It drives a priority instance and a round-robin instance from shared inputs.
// A queue-free behavioural model is checked against both instances on every negedge, together with literal expectations.
module tb_arb_mux_n_to_1;

  localparam int WL = 8;
  localparam int N  = 5;

  logic              clk;
  logic              rst_n;
  logic [N-1:0][WL-1:0] data_in;
  logic [N-1:0]      sel;
  logic              out_ready;
  logic              clear_conflict;

  logic [N-1:0]  p_sel_ack, r_sel_ack;
  logic [WL-1:0] p_out, r_out;
  logic          p_vld, r_vld;
  logic [N-1:0]  p_grant, r_grant;
  logic [2:0]    p_idx, r_idx;
  logic          p_conf, r_conf;

  int tests = 0;
  int fails = 0;

  arb_mux_n_to_1 #(.WORD_LENGTH(WL), .NUM_INPUTS(N), .MODE(mux_pkg::ARB_PRIORITY)) u_prio (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .sel(sel), .out_ready(out_ready),
    .clear_conflict(clear_conflict), .sel_ack(p_sel_ack), .out(p_out), .out_valid(p_vld),
    .grant(p_grant), .grant_idx(p_idx), .conflict(p_conf));

  arb_mux_n_to_1 #(.WORD_LENGTH(WL), .NUM_INPUTS(N), .MODE(mux_pkg::ARB_ROUND_ROBIN)) u_rr (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .sel(sel), .out_ready(out_ready),
    .clear_conflict(clear_conflict), .sel_ack(r_sel_ack), .out(r_out), .out_valid(r_vld),
    .grant(r_grant), .grant_idx(r_idx), .conflict(r_conf));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state. Index 0 is the priority instance; index 1 is the round-robin instance.
  logic [WL-1:0] m_out   [2];
  logic          m_vld   [2];
  logic [N-1:0]  m_grant [2];
  int            m_idx   [2];
  int            m_last  [2];
  logic          m_conf  [2];

  function automatic int winner(input int d, input logic [N-1:0] s);
    if (s == '0) return -1;
    if (d == 0) begin
      for (int i = 0; i < N; i++) if (s[i]) return i;
    end else begin
      for (int k = 1; k <= N; k++) if (s[(m_last[d] + k) % N]) return (m_last[d] + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_ack(input int d);
    logic [N-1:0] e;
    int w;
    e = '0;
    w = winner(d, sel);
    if (rst_n && (!m_vld[d] || out_ready) && w >= 0) e[w] = 1'b1;
    return e;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int d = 0; d < 2; d++) begin
        m_out[d] = '0; m_vld[d] = 1'b0; m_grant[d] = '0; m_idx[d] = 0;
        m_last[d] = N - 1; m_conf[d] = 1'b0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        int  w;
        bit  acc;
        w   = winner(d, sel);
        acc = (!m_vld[d] || out_ready) && (w >= 0);
        if (acc) m_conf[d] = ($countones(sel) >= 2) ? 1'b1 : (clear_conflict ? 1'b0 : m_conf[d]);
        else if (clear_conflict) m_conf[d] = 1'b0;
        if (acc) begin
          m_out[d] = data_in[w]; m_vld[d] = 1'b1; m_grant[d] = '0; m_grant[d][w] = 1'b1;
          m_idx[d] = w; m_last[d] = w;
        end else if (!m_vld[d] || out_ready) begin
          m_vld[d] = 1'b0; m_grant[d] = '0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("p_sel_ack", 32'(p_sel_ack), 32'(exp_ack(0)));
      chk("p_out",     32'(p_out),     32'(m_out[0]));
      chk("p_valid",   32'(p_vld),     32'(m_vld[0]));
      chk("p_grant",   32'(p_grant),   32'(m_grant[0]));
      chk("p_idx",     32'(p_idx),     32'(m_idx[0]));
      chk("p_conf",    32'(p_conf),    32'(m_conf[0]));
      chk("r_sel_ack", 32'(r_sel_ack), 32'(exp_ack(1)));
      chk("r_out",     32'(r_out),     32'(m_out[1]));
      chk("r_valid",   32'(r_vld),     32'(m_vld[1]));
      chk("r_grant",   32'(r_grant),   32'(m_grant[1]));
      chk("r_idx",     32'(r_idx),     32'(m_idx[1]));
      chk("r_conf",    32'(r_conf),    32'(m_conf[1]));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  int rr_exp [6] = '{0, 1, 2, 3, 4, 0};

  initial begin
    rst_n = 1'b0; sel = '0; out_ready = 1'b0; clear_conflict = 1'b0;
    for (int i = 0; i < N; i++) data_in[i] = WL'(8'h11 * (i + 1));
    cyc();
    chk("reset_out",   32'(p_out), 32'h0);
    chk("reset_valid", 32'(p_vld), 32'h0);
    chk("reset_grant", 32'(p_grant), 32'h0);
    chk("reset_idx",   32'(r_idx), 32'h0);
    chk("reset_conf",  32'(r_conf), 32'h0);
    cyc();
    rst_n = 1'b1;

    // Priority pick with multiple requests sets the conflict flag.
    data_in[1] = 8'hA1; sel = 5'b10110; out_ready = 1'b1;
    #1 chk("prio_sel_ack", 32'(p_sel_ack), 32'b00010);
    cyc();
    sel = '0;
    chk("prio_out",  32'(p_out),  32'hA1);
    chk("prio_idx",  32'(p_idx),  32'd1);
    chk("prio_conf", 32'(p_conf), 32'd1);
    cyc();
    clear_conflict = 1'b1;
    cyc();
    clear_conflict = 1'b0;

    // Stall: the held word survives, stalled multi-requests do not set conflict, and rr_ptr does not move.
    data_in[0] = 8'h3C; data_in[2] = 8'hC2; sel = 5'b00001;
    cyc();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sel = (i < 2) ? 5'b00110 : 5'b00100;
      #1 chk("stall_ack", 32'(p_sel_ack), 32'h0);
      chk("stall_out", 32'(p_out), 32'h3C);
      cyc();
    end
    out_ready = 1'b1;
    #1 chk("release_ack", 32'(p_sel_ack), 32'b00100);
    chk("stall_conf", 32'(p_conf), 32'h0);
    cyc();
    sel = 5'b11111;
    chk("release_out",   32'(p_out),   32'hC2);
    chk("release_idx",   32'(p_idx),   32'd2);
    chk("release_grant", 32'(r_grant), 32'b00100);
    cyc();
    sel = '0;
    chk("rr_after_stall", 32'(r_idx), 32'd3);
    cyc();

    // Idle slot: out keeps the last word, while valid and grant drop.
    data_in[0] = 8'h55; sel = 5'b00001;
    cyc();
    sel = '0;
    cyc();
    chk("idle_valid", 32'(p_vld),   32'h0);
    chk("idle_out",   32'(p_out),   32'h55);
    chk("idle_grant", 32'(p_grant), 32'h0);

    // When conflict is set and cleared in the same cycle, the set wins.
    sel = 5'b00011;
    cyc();
    sel = 5'b01001; clear_conflict = 1'b1;
    cyc();
    chk("conf_set_wins", 32'(p_conf), 32'h1);
    sel = '0;
    cyc();
    clear_conflict = 1'b0;
    chk("conf_cleared", 32'(p_conf), 32'h0);

    // Reset during a stall, then a round-robin sweep from channel 0.
    data_in[0] = 8'h3C; sel = 5'b00001;
    cyc();
    out_ready = 1'b0; sel = 5'b00100;
    cyc();
    rst_n = 1'b0;
    #1 chk("rst_out",   32'(p_out),     32'h0);
    chk("rst_valid",    32'(r_vld),     32'h0);
    chk("rst_ack",      32'(p_sel_ack), 32'h0);
    cyc();
    rst_n = 1'b1; out_ready = 1'b1; sel = 5'b11111;
    for (int i = 0; i < 6; i++) begin
      cyc();
      chk("rr_seq", 32'(r_idx), 32'(rr_exp[i]));
    end

    // Mixed directed pattern, checked by the model only.
    for (int i = 0; i < 24; i++) begin
      sel            = 5'((i * 7 + 3) % 32);
      out_ready      = (i % 3) != 0;
      clear_conflict = (i % 5) == 4;
      data_in[i % N] = 8'(i * 13 + 1);
      cyc();
    end
    sel = '0; out_ready = 1'b1; clear_conflict = 1'b0;
    cyc();
    cyc();
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
